// File: rtl/apb3_master_bridge.sv
// Single-outstanding APB3 master: valid/ready request -> SETUP/ACCESS transfer -> valid/ready response.
// An ACCESS phase that waits too long on PREADY is aborted with a timeout error response.
module apb3_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   wait_reg, wait_next;
  logic            psel_reg, psel_next;
  logic            penable_reg, penable_next;
  logic [31:0]     paddr_reg, paddr_next;
  logic            pwrite_reg, pwrite_next;
  logic [31:0]     pwdata_reg, pwdata_next;
  logic            rsp_valid_reg, rsp_valid_next;
  logic [31:0]     rsp_rdata_reg, rsp_rdata_next;
  logic            rsp_err_reg, rsp_err_next;
  logic            rsp_timeout_reg, rsp_timeout_next;
  logic            timeout_hit;

  // With TIMEOUT_CYCLES == 0 the compare is masked off and the counter only saturates.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(wait_reg) == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_next       = state_reg;
    wait_next        = wait_reg;
    psel_next        = psel_reg;
    penable_next     = penable_reg;
    paddr_next       = paddr_reg;
    pwrite_next      = pwrite_reg;
    pwdata_next      = pwdata_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_err_next     = rsp_err_reg;
    rsp_timeout_next = rsp_timeout_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          paddr_next   = {req_addr[31:2], 2'b00};
          pwrite_next  = req_write;
          pwdata_next  = req_write ? req_wdata : 32'h0;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          state_next   = SETUP;
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        wait_next    = '0;
        state_next   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_rdata_next   = pwrite_reg ? 32'h0 : PRDATA;
          rsp_err_next     = PSLVERR;
          rsp_timeout_next = 1'b0;
          rsp_valid_next   = 1'b1;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          state_next       = RESP;
        end else if (timeout_hit) begin
          rsp_rdata_next   = ERR_RDATA;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          rsp_valid_next   = 1'b1;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          state_next       = RESP;
        end else if (wait_reg != '1) begin
          wait_next = wait_reg + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg       <= IDLE;
      wait_reg        <= '0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      paddr_reg       <= 32'h0;
      pwrite_reg      <= 1'b0;
      pwdata_reg      <= 32'h0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= 32'h0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wait_reg        <= wait_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      paddr_reg       <= paddr_next;
      pwrite_reg      <= pwrite_next;
      pwdata_reg      <= pwdata_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  assign req_ready   = (state_reg == IDLE);
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign PSEL        = psel_reg;
  assign PENABLE     = penable_reg;
  assign PADDR       = paddr_reg;
  assign PWRITE      = pwrite_reg;
  assign PWDATA      = pwdata_reg;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Bench for apb3_master_bridge: a small APB config-register slave with programmable wait states
// and error injection, plus a transaction-level reference model of the expected responses.
module tb_apb3_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int ncmp = 0;
  int nfail = 0;

  apb3_master_bridge dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave: PREADY after wait_cfg ACCESS cycles (high outside ACCESS to prove it is ignored there)
  int          wait_cfg = 0;
  logic        err_cfg = 1'b0;
  logic [31:0] err_data_cfg = 32'h0;
  int          acc_cnt = 0;
  logic [31:0] slave_mem [16];
  logic [31:0] model_mem [16];

  assign PREADY  = !(PSEL && PENABLE) || (acc_cnt == wait_cfg);
  assign PSLVERR = err_cfg;
  assign PRDATA  = err_cfg ? err_data_cfg : slave_mem[PADDR[5:2]];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && !err_cfg) slave_mem[PADDR[5:2]] <= PWDATA;
  end

  // Protocol monitor: idle gap before each SETUP, stable controls, ACCESS cycle count
  logic        prev_psel = 1'b0;
  logic [31:0] mon_addr = 32'h0;
  logic [31:0] mon_wdata = 32'h0;
  logic        mon_write = 1'b0;
  int          mon_acc = 0;

  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (PENABLE) chk("penable_without_psel", 32'(PSEL), 32'd1);
      if (PSEL && !PENABLE) begin
        chk("idle_gap_before_setup", 32'(prev_psel), 32'd0);
        mon_addr = PADDR; mon_wdata = PWDATA; mon_write = PWRITE; mon_acc = 0;
      end else if (PSEL) begin
        chk("paddr_stable", PADDR, mon_addr);
        chk("pwdata_stable", PWDATA, mon_wdata);
        chk("pwrite_stable", 32'(PWRITE), 32'(mon_write));
        mon_acc++;
      end
    end
    prev_psel = PSEL;
  end

  // One transfer, started and finished at a negedge with the bridge idle
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int wt, input logic err, input logic [31:0] edata, input int hold);
    logic [31:0] exp_rdata, s_rdata;
    logic        exp_err, exp_tmo, s_err, s_tmo;
    int          exp_lat, exp_acc, lat;
    if (wt >= 16) begin
      exp_rdata = 32'hDEADBEEF; exp_err = 1'b1; exp_tmo = 1'b1; exp_lat = 18; exp_acc = 16;
    end else begin
      exp_rdata = wr ? 32'h0 : (err ? edata : model_mem[addr[5:2]]);
      exp_err = err; exp_tmo = 1'b0; exp_lat = 3 + wt; exp_acc = wt + 1;
      if (wr && !err) model_mem[addr[5:2]] = wdata;
    end
    wait_cfg = wt; err_cfg = err; err_data_cfg = edata;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(negedge PCLK);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom);
    chk("setup_psel", 32'(PSEL), 32'd1);
    chk("setup_penable", 32'(PENABLE), 32'd0);
    chk("setup_paddr", PADDR, {addr[31:2], 2'b00});
    chk("setup_pwrite", 32'(PWRITE), 32'(wr));
    chk("setup_pwdata", PWDATA, wr ? wdata : 32'h0);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge PCLK);
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    chk("access_cycles", 32'(mon_acc), 32'(exp_acc));
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_tmo));
    chk("psel_in_resp", 32'(PSEL), 32'd0);
    s_rdata = rsp_rdata; s_err = rsp_err; s_tmo = rsp_timeout;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom);
      @(negedge PCLK);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, s_rdata);
      chk("hold_rsp_err", 32'({rsp_err, rsp_timeout}), 32'({s_err, s_tmo}));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_psel", 32'(PSEL), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_psel", 32'(PSEL), 32'd0);
    $display("txn wr=%0d addr=%h wdata=%h wait=%0d err=%0d -> rdata=%h err=%0d tmo=%0d lat=%0d",
             wr, addr, wdata, wt, err, s_rdata, s_err, s_tmo, lat);
  endtask

  initial begin
    logic [31:0] w0, w1, w2;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = 32'h0;
      model_mem[i] = 32'h0;
    end
    #1;
    chk("reset_outputs", {rsp_rdata[30:0] | PADDR[30:0] | PWDATA[30:0], rsp_rdata[31] | PADDR[31] | PWDATA[31]}, 32'h0);
    chk("reset_ctrl", 32'({rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE}), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    txn(1'b1, 32'h0000_0000, 32'hA5A5_1234, 0, 1'b0, 32'h0, 0);
    txn(1'b1, 32'h0000_0004, 32'h1357_9BDF, 0, 1'b0, 32'h0, 1);
    txn(1'b0, 32'h0000_0004, $urandom, 1, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h0000_0000, $urandom, 0, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h0000_0008, $urandom, 0, 1'b1, 32'hDEADBEEF, 0);
    txn(1'b0, 32'h0000_000C, $urandom, 255, 1'b0, 32'h0, 1);

    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    txn(1'b1, 32'h0000_0010, w0, 0, 1'b0, 32'h0, 5);
    txn(1'b1, 32'h0000_0014, w1, 0, 1'b0, 32'h0, 0);
    txn(1'b1, 32'h0000_0018, w2, 0, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h0000_0010, $urandom, 0, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h0000_0014, $urandom, 0, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h0000_0018, $urandom, 0, 1'b0, 32'h0, 0);

    // Reset pulse in the middle of a stalled ACCESS phase
    wait_cfg = 255; err_cfg = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_001C; req_wdata = 32'hCAFE_F00D;
    @(negedge PCLK);
    req_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("pre_reset_access", 32'({PSEL, PENABLE}), 32'd3);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_reset_psel", 32'({PSEL, PENABLE}), 32'd0);
    chk("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_reset_req_ready", 32'(req_ready), 32'd1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    $display("reset pulse during ACCESS applied");
    txn(1'b0, 32'h0000_001C, $urandom, 0, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h0000_0003, $urandom, 2, 1'b0, 32'h0, 0);

    for (int n = 0; n < 24; n++) begin
      txn(1'($urandom), $urandom, $urandom,
          ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3)),
          ($urandom_range(0, 5) == 0), $urandom, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
